// File: rtl/text_pkg.sv
// Shared types and constants for the text loader and the effect blocks it feeds.
package text_pkg;

  localparam logic [3:0] CHECK_IDLE = 4'hF;
  localparam logic [2:0] NUM_SLOTS  = 3'd7;
  localparam logic [2:0] LAST_SLOT  = 3'd6;
  localparam int         SLOT_W     = 3;
  localparam int         CHAR_W     = 7;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [CHAR_W-1:0] char_t;

  typedef enum logic {S_IDLE, S_BCAST} state_t;

endpackage

// File: rtl/text_loader_refresh_tick.sv
// Terminal-count counter: one-cycle tick every CYCLES clocks, first tick CYCLES-1 edges after reset.
// Free-running, no enable and no backpressure.
module refresh_tick #(
  parameter int           W      = 28,
  parameter logic [W-1:0] CYCLES = 28'd50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CYCLES - {{(W-1){1'b0}}, 1'b1});
    cnt_d = tick ? '0 : cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/text_loader.sv
// Edit buffer -> shown buffer -> slot-by-slot broadcast on (check, text_index); commit to check=0 is 2 edges.
// char_ready drops once 7 characters are held; broadcasts never stall editing.
module text_loader import text_pkg::*; #(
  parameter logic [6:0]  BLANK_INDEX    = 7'd0,
  parameter logic [27:0] REFRESH_CYCLES = 28'd50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [6:0] char_code,
  output logic       char_ready,
  input  logic       clear,
  input  logic       commit,
  output logic [3:0] check,
  output logic [6:0] text_index,
  output logic       busy,
  output logic [2:0] fill_level
);

  state_t state_q, state_d;
  slot_t  slot_q, slot_d;
  logic   pending_q, pending_d;
  char_t  edit_q [NUM_SLOTS];
  char_t  edit_d [NUM_SLOTS];
  char_t  shown_q [NUM_SLOTS];
  char_t  shown_d [NUM_SLOTS];
  char_t  merged [NUM_SLOTS];
  slot_t  fill_q, fill_d;
  logic   char_ready_q, char_ready_d;
  logic   start_bcast, tick, wr;

  refresh_tick #(.W(28), .CYCLES(REFRESH_CYCLES)) u_refresh (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      pending_q    <= 1'b1;
      edit_q       <= '{default: BLANK_INDEX};
      shown_q      <= '{default: BLANK_INDEX};
      fill_q       <= '0;
      char_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      pending_q    <= pending_d;
      edit_q       <= edit_d;
      shown_q      <= shown_d;
      fill_q       <= fill_d;
      char_ready_q <= char_ready_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    start_bcast = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          state_d     = S_BCAST;
          slot_d      = '0;
          start_bcast = 1'b1;
        end
      end
      S_BCAST: begin
        if (slot_q == LAST_SLOT) begin
          state_d = S_IDLE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    check      = CHECK_IDLE;
    text_index = '0;
    busy       = 1'b0;
    if (state_q == S_BCAST) begin
      check      = {1'b0, slot_q};
      text_index = shown_q[slot_q];
      busy       = 1'b1;
    end
  end

  // The character written alongside a commit is folded in before the snapshot.
  always_comb begin
    wr     = char_valid && char_ready_q && !clear;
    merged = edit_q;
    if (wr) merged[fill_q] = char_code;
    edit_d  = merged;
    fill_d  = fill_q + {2'b00, wr};
    shown_d = shown_q;
    if (clear) begin
      edit_d = '{default: BLANK_INDEX};
      fill_d = '0;
    end else if (commit) begin
      shown_d = merged;
      edit_d  = '{default: BLANK_INDEX};
      fill_d  = '0;
    end
    char_ready_d = (fill_d != NUM_SLOTS);
    pending_d    = (pending_q && !start_bcast) || (commit && !clear) || tick;
  end

  assign char_ready = char_ready_q;
  assign fill_level = fill_q;

endmodule
